// File: rtl/vga_timing_gen.sv
// Raster timing generator: walks (hc, vc) in raster order and registers
// the decoded position, active-video flag, sync pulses and frame strobes.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic       vblank_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);
  // Inclusive sync bounds keep every constant inside 10 bits even at 1024.
  localparam logic [9:0] HS_BEG  = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG  = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_LAST = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [9:0] hc;
  logic [9:0] vc;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
    end else begin
      hc <= hc + 10'd1;
    end
  end

  logic blank_d;
  logic hs_d;
  logic vs_d;
  logic fs_d;
  logic vbs_d;

  always_comb begin
    blank_d = (hc < H_VIS) && (vc < V_VIS);
    hs_d    = !((hc >= HS_BEG) && (hc <= HS_LAST));
    vs_d    = !((vc >= VS_BEG) && (vc <= VS_LAST));
    fs_d    = (hc == '0) && (vc == '0);
    vbs_d   = (hc == '0) && (vc == V_VIS);
  end

  // All outputs share one register stage so downstream sees them unskewed.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      DrawX        <= '0;
      DrawY        <= '0;
      blank        <= 1'b0;
      hs           <= 1'b1;
      vs           <= 1'b1;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      DrawX        <= hc;
      DrawY        <= vc;
      blank        <= blank_d;
      hs           <= hs_d;
      vs           <= vs_d;
      frame_start  <= fs_d;
      vblank_start <= vbs_d;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 timing plus a tiny override
// instance whose whole frame fits in a short run.
module tb_vga_timing_gen;

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;

  always #20 vga_clk = ~vga_clk;

  logic [9:0] d_x, d_y;
  logic       d_blank, d_hs, d_vs, d_fs, d_vbs;
  logic [9:0] s_x, s_y;
  logic       s_blank, s_hs, s_vs, s_fs, s_vbs;

  vga_timing_gen u_dflt (
    .vga_clk      (vga_clk),
    .reset        (reset),
    .DrawX        (d_x),
    .DrawY        (d_y),
    .blank        (d_blank),
    .hs           (d_hs),
    .vs           (d_vs),
    .frame_start  (d_fs),
    .vblank_start (d_vbs)
  );

  vga_timing_gen #(
    .H_VISIBLE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_VISIBLE (4), .V_FP (1), .V_SYNC (1), .V_BP (1)
  ) u_small (
    .vga_clk      (vga_clk),
    .reset        (reset),
    .DrawX        (s_x),
    .DrawY        (s_y),
    .blank        (s_blank),
    .hs           (s_hs),
    .vs           (s_vs),
    .frame_start  (s_fs),
    .vblank_start (s_vbs)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      if (bad <= 30)
        $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_dx"}, d_x, 0);
    chk({tag, "_dy"}, d_y, 0);
    chk({tag, "_dhs"}, d_hs, 1);
    chk({tag, "_dvs"}, d_vs, 1);
    chk({tag, "_dblank"}, d_blank, 0);
    chk({tag, "_dfs"}, d_fs, 0);
    chk({tag, "_dvbs"}, d_vbs, 0);
    chk({tag, "_sx"}, s_x, 0);
    chk({tag, "_shs"}, s_hs, 1);
    chk({tag, "_sblank"}, s_blank, 0);
  endtask

  // Aggregates over the first run
  int   d_blank_n = 0;
  int   d_hs_low  = 0;
  int   d_hs_fall = -1;
  int   d_hs_rise = -1;
  logic d_hs_prev = 1'b1;
  int   s_fs_last = -1;
  int   s_fs_gap_bad = 0;
  int   s_fs_n    = 0;
  int   s_vbs_n   = 0;
  int   s_vbs_first = -1;
  int   s_vs_low  = 0;
  int   s_blank_bad = 0;

  // Expected outputs at raster index i, computed from the raw geometry.
  task automatic check_idx(input int i, input bit agg);
    int dx, dy, sx, sy;
    dx = i % 800;
    dy = (i / 800) % 525;
    sx = i % 12;
    sy = (i / 12) % 7;
    chk("d_x", d_x, dx);
    chk("d_y", d_y, dy);
    chk("d_blank", d_blank, int'(dx < 640 && dy < 480));
    chk("d_hs", d_hs, int'(!(dx >= 656 && dx <= 751)));
    chk("d_vs", d_vs, int'(!(dy == 490 || dy == 491)));
    chk("d_fs", d_fs, int'(dx == 0 && dy == 0));
    chk("d_vbs", d_vbs, int'(dx == 0 && dy == 480));
    chk("s_x", s_x, sx);
    chk("s_y", s_y, sy);
    chk("s_blank", s_blank, int'(sx < 8 && sy < 4));
    chk("s_hs", s_hs, int'(!(sx == 9 || sx == 10)));
    chk("s_vs", s_vs, int'(sy != 5));
    chk("s_fs", s_fs, int'(sx == 0 && sy == 0));
    chk("s_vbs", s_vbs, int'(sx == 0 && sy == 4));
    if (agg && i < 800) begin
      if (d_blank) d_blank_n++;
      if (!d_hs) d_hs_low++;
      if (d_hs_prev && !d_hs) d_hs_fall = int'(d_x);
      if (!d_hs_prev && d_hs) d_hs_rise = int'(d_x);
      d_hs_prev = d_hs;
    end
    if (agg && i < 1680) begin
      if (s_fs) begin
        s_fs_n++;
        if (s_fs_last >= 0 && i - s_fs_last != 84) s_fs_gap_bad++;
        s_fs_last = i;
      end
      if (s_vbs) begin
        s_vbs_n++;
        if (s_vbs_first < 0) s_vbs_first = i + 1;
      end
      if (!s_vs) s_vs_low++;
      if (s_blank && s_y >= 4) s_blank_bad++;
    end
  endtask

  initial begin
    tick;
    chk_reset("rst0");
    tick;
    chk_reset("rst1");
    reset = 1'b0;

    // Edge k shows raster index k-1
    for (int k = 1; k <= 2301; k++) begin
      tick;
      check_idx(k - 1, 1'b1);
    end

    chk("line_blank_cnt", d_blank_n, 640);
    chk("line_hs_low", d_hs_low, 96);
    chk("line_hs_fall_x", d_hs_fall, 656);
    chk("line_hs_rise_x", d_hs_rise, 752);
    chk("s_fs_count", s_fs_n, 20);
    chk("s_fs_gap_bad", s_fs_gap_bad, 0);
    chk("s_vbs_count", s_vbs_n, 20);
    chk("s_vbs_first_edge", s_vbs_first, 49);
    chk("s_vs_low_cnt", s_vs_low, 240);
    chk("s_blank_in_vblank", s_blank_bad, 0);

    // Reset asserted mid-line while hs is low (DrawX=700, DrawY=2)
    chk("pre_rst_hs", d_hs, 0);
    chk("pre_rst_x", d_x, 700);
    reset = 1'b1;
    #1;
    chk_reset("async");
    tick;
    chk_reset("hold0");
    tick;
    chk_reset("hold1");
    reset = 1'b0;

    tick;
    chk("rel_blank", d_blank, 1);
    chk("rel_fs", d_fs, 1);
    check_idx(0, 1'b0);
    for (int k = 2; k <= 200; k++) begin
      tick;
      check_idx(k - 1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
